// File: rtl/endeavour_led_pkg.sv
// Shared constants, FSM state types and the byte-strobe merge helper for the
// AXI4-Lite LED register slave.
package endeavour_led_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_LED     = 2'd1;
    localparam logic [1:0] REG_PERIOD  = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    localparam int unsigned CTRL_BLINK_EN_BIT = 0;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/endeavour_led_axil_slave_if.sv
// AXI4-Lite channel bundle between a bus master and the LED register slave.
interface endeavour_led_axil_slave_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
               S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
               S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
               S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
               S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
               S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
               S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

endinterface

// File: rtl/endeavour_led_blinker.sv
// Half-period counter and blink phase; phase idles high so the LEDs show the
// plain pattern whenever blinking is off.
module endeavour_led_blinker (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic [31:0] period_i,
    input  logic        clear_i,
    output logic        phase_o
);

    logic [31:0] cnt_q;
    logic        phase_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else if (clear_i || !enable_i || (period_i == 32'd0)) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else if (cnt_q >= period_i - 32'd1) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/endeavour_led_axil_slave.sv
// AXI4-Lite slave with CTRL/LED/PERIOD/SCRATCH registers driving led_o.
// Blinking is built only when ENDEAVOUR_LED_BLINK_EN is defined.
module endeavour_led_axil_slave
    import endeavour_led_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int LED_WIDTH          = 8
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    endeavour_led_axil_slave_if.slave s_axi,
    output logic [LED_WIDTH-1:0]     led_o
);

    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;
    assign awaddr = s_axi.S_AXI_AWADDR;
    assign araddr = s_axi.S_AXI_ARADDR;

    logic [3:0][C_S_AXI_DATA_WIDTH-1:0] regs_q;

    wr_state_e                     wr_state_q;
    logic                          awready_q, wready_q, bvalid_q;
    logic [1:0]                    wr_idx_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [3:0]                    wstrb_q;
    logic                          aw_hs, w_hs;

    assign aw_hs = s_axi.S_AXI_AWVALID & awready_q;
    assign w_hs  = s_axi.S_AXI_WVALID & wready_q;

    // Commit happens on whichever handshake completes the address/data pair.
    logic                          wr_en;
    logic [1:0]                    wr_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
    logic [3:0]                    wr_strb;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = awaddr[3:2];
        wr_data = s_axi.S_AXI_WDATA;
        wr_strb = s_axi.S_AXI_WSTRB;
        unique case (wr_state_q)
            WR_IDLE:    wr_en = aw_hs & w_hs;
            WR_WAIT_W: begin
                wr_en  = w_hs;
                wr_idx = wr_idx_q;
            end
            WR_WAIT_AW: begin
                wr_en   = aw_hs;
                wr_data = wdata_q;
                wr_strb = wstrb_q;
            end
            default:    wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            wr_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            unique case (wr_state_q)
                WR_IDLE: begin
                    if (aw_hs && w_hs) begin
                        wr_state_q <= WR_RESP;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b0;
                        bvalid_q   <= 1'b1;
                    end else if (aw_hs) begin
                        wr_state_q <= WR_WAIT_W;
                        wr_idx_q   <= awaddr[3:2];
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                    end else if (w_hs) begin
                        wr_state_q <= WR_WAIT_AW;
                        wdata_q    <= s_axi.S_AXI_WDATA;
                        wstrb_q    <= s_axi.S_AXI_WSTRB;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b0;
                    end else begin
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                WR_WAIT_W: begin
                    if (w_hs) begin
                        wr_state_q <= WR_RESP;
                        wready_q   <= 1'b0;
                        bvalid_q   <= 1'b1;
                    end
                end
                WR_WAIT_AW: begin
                    if (aw_hs) begin
                        wr_state_q <= WR_RESP;
                        awready_q  <= 1'b0;
                        bvalid_q   <= 1'b1;
                    end
                end
                default: begin
                    if (s_axi.S_AXI_BREADY) begin
                        wr_state_q <= WR_IDLE;
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            regs_q <= '0;
        end else if (wr_en) begin
            regs_q[wr_idx] <= apply_strb(regs_q[wr_idx], wr_data, wr_strb);
        end
    end

    rd_state_e                     rd_state_q;
    logic                          arready_q, rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

    // Captures regs_q before any same-edge write lands, so reads see the old value.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            unique case (rd_state_q)
                RD_IDLE: begin
                    if (s_axi.S_AXI_ARVALID && arready_q) begin
                        rd_state_q <= RD_DATA;
                        rdata_q    <= regs_q[araddr[3:2]];
                        rvalid_q   <= 1'b1;
                        arready_q  <= 1'b0;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                default: begin
                    if (s_axi.S_AXI_RREADY) begin
                        rd_state_q <= RD_IDLE;
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = RESP_OKAY;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = RESP_OKAY;

    logic [LED_WIDTH-1:0] led_q;

`ifdef ENDEAVOUR_LED_BLINK_EN
    logic phase;
    logic blink_clear;

    assign blink_clear = wr_en && ((wr_idx == REG_CTRL) || (wr_idx == REG_PERIOD));

    endeavour_led_blinker u_blinker (
        .clk_i    (ACLK),
        .rst_ni   (ARESETN),
        .enable_i (regs_q[REG_CTRL][CTRL_BLINK_EN_BIT]),
        .period_i (regs_q[REG_PERIOD]),
        .clear_i  (blink_clear),
        .phase_o  (phase)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) led_q <= '0;
        else          led_q <= regs_q[REG_LED][LED_WIDTH-1:0] & {LED_WIDTH{phase}};
    end
`else
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) led_q <= '0;
        else          led_q <= regs_q[REG_LED][LED_WIDTH-1:0];
    end
`endif

    assign led_o = led_q;

    logic unused_ok;
    assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, awaddr[1:0], araddr[1:0]};

endmodule

// File: tb/tb_endeavour_led_axil_slave.sv
// Randomised self-checking bench for the AXI4-Lite LED slave against a
// register-map model; blink timing is checked when ENDEAVOUR_LED_BLINK_EN is set.
module tb_endeavour_led_axil_slave;

    localparam int LW = 8;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [LW-1:0] led_o;

    endeavour_led_axil_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

    endeavour_led_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .LED_WIDTH          (LW)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .s_axi   (bus.slave),
        .led_o   (led_o)
    );

    always #5 ACLK = ~ACLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [4];

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        bit aw_done, w_done, aw_now, w_now, got_b;
        aw_done = 0; w_done = 0; got_b = 0;
        bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb; bus.S_AXI_WVALID = 1'b1;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            aw_now = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_now  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            tick();
            if (aw_now) begin aw_done = 1; bus.S_AXI_AWVALID = 1'b0; end
            if (w_now) begin w_done = 1; bus.S_AXI_WVALID = 1'b0; end
        end
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        checks++;
        if (!(aw_done && w_done)) begin
            errors++;
            $display("FAIL write_handshake addr=%h got aw=%0d w=%0d want 1 1", addr, aw_done, w_done);
        end else begin
            model[addr[3:2]] = merge(model[addr[3:2]], data, strb);
        end
        bus.S_AXI_BREADY = 1'b1;
        for (int i = 0; i < 20 && !got_b; i++) begin
            if (bus.S_AXI_BVALID) begin
                got_b = 1;
                checks++;
                if (bus.S_AXI_BRESP !== 2'b00) begin
                    errors++;
                    $display("FAIL bresp got %b want 00", bus.S_AXI_BRESP);
                end
            end
            tick();
        end
        bus.S_AXI_BREADY = 1'b0;
        checks++;
        if (!got_b) begin
            errors++;
            $display("FAIL bvalid_timeout addr=%h got 0 want 1", addr);
        end
    endtask

    task automatic do_read(input logic [3:0] addr, output logic [31:0] data);
        bit ar_done, got_r;
        ar_done = 0; got_r = 0; data = '0;
        bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 20 && !ar_done; i++) begin
            ar_done = bus.S_AXI_ARREADY;
            tick();
        end
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b1;
        for (int i = 0; i < 20 && !got_r; i++) begin
            if (bus.S_AXI_RVALID) begin
                got_r = 1;
                data = bus.S_AXI_RDATA;
                checks++;
                if (bus.S_AXI_RRESP !== 2'b00) begin
                    errors++;
                    $display("FAIL rresp got %b want 00", bus.S_AXI_RRESP);
                end
            end
            tick();
        end
        bus.S_AXI_RREADY = 1'b0;
        checks++;
        if (!(ar_done && got_r)) begin
            errors++;
            $display("FAIL read_timeout addr=%h got ar=%0d r=%0d want 1 1", addr, ar_done, got_r);
        end
    endtask

    task automatic read_all(input string tag);
        logic [31:0] rd;
        for (int i = 0; i < 4; i++) begin
            do_read(4'(i * 4), rd);
            checks++;
            if (rd !== model[i]) begin
                errors++;
                $display("FAIL %s reg%0d got %h want %h", tag, i, rd, model[i]);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID,
             bus.S_AXI_RVALID} !== 5'b0 || bus.S_AXI_RDATA !== 32'h0 || led_o !== '0) begin
            errors++;
            $display("FAIL %s got rdy/valid=%b rdata=%h led=%h want 00000 0 0", tag,
                     {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY,
                      bus.S_AXI_BVALID, bus.S_AXI_RVALID}, bus.S_AXI_RDATA, led_o);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) model[i] = '0;
        repeat (3) @(posedge ACLK);
        #1;
        check_idle_outputs("reset_hold");
        ARESETN = 1'b1;
        tick();
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready got %b want 111",
                     {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
        end
        read_all("reset_regs");
    endtask

    task automatic test_regmap();
        for (int i = 0; i < 4; i++) do_write(4'(i * 4), 32'(i + 1), 4'hF);
        read_all("regmap");
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [3:0]  addr;
        for (int n = 0; n < 16; n++) begin
            addr = {2'($urandom_range(0, 3)), 2'b00};
            do_write(addr, $urandom, 4'($urandom_range(0, 15)));
            addr = {2'($urandom_range(0, 3)), 2'b00};
            do_read(addr, rd);
            checks++;
            if (rd !== model[addr[3:2]]) begin
                errors++;
                $display("FAIL random_read addr=%h got %h want %h", addr, rd, model[addr[3:2]]);
            end
        end
        read_all("random_final");
    endtask

    task automatic test_strobe();
        logic [31:0] rd;
        do_write(4'hC, 32'hFFFF_FFFF, 4'hF);
        do_write(4'hC, 32'h0000_0012, 4'b0001);
        do_read(4'hC, rd);
        checks++;
        if (rd !== 32'hFFFF_FF12) begin
            errors++;
            $display("FAIL strobe_byte0 got %h want ffffff12", rd);
        end
        do_write(4'hC, 32'h0, 4'h0);
        do_read(4'hC, rd);
        checks++;
        if (rd !== 32'hFFFF_FF12) begin
            errors++;
            $display("FAIL strobe_none got %h want ffffff12", rd);
        end
    endtask

    task automatic test_split(input bit aw_first);
        logic [3:0]  addr;
        logic [31:0] data, rd, old_v;
        addr  = {2'($urandom_range(1, 3)), 2'b00};
        data  = $urandom;
        old_v = model[addr[3:2]];
        if (aw_first) begin bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1; end
        else begin bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1; end
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== (aw_first ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL split_wait_ready aw_first=%0d got %b want %b", aw_first,
                     {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, aw_first ? 2'b01 : 2'b10);
        end
        do_read(addr, rd);
        checks++;
        if (rd !== old_v) begin
            errors++;
            $display("FAIL split_early_commit got %h want %h", rd, old_v);
        end
        checks++;
        if (bus.S_AXI_BVALID !== 1'b0) begin
            errors++;
            $display("FAIL split_early_bvalid got %b want 0", bus.S_AXI_BVALID);
        end
        if (aw_first) begin bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1; end
        else begin bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1; end
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        model[addr[3:2]] = data;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.S_AXI_BVALID !== 1'b1) begin
                errors++;
                $display("FAIL split_bvalid_hold cycle %0d got %b want 1", i, bus.S_AXI_BVALID);
            end
            tick();
        end
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        checks++;
        if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY} !== 2'b01) begin
            errors++;
            $display("FAIL split_b_release got bvalid/awready=%b want 01",
                     {bus.S_AXI_BVALID, bus.S_AXI_AWREADY});
        end
        do_read(addr, rd);
        checks++;
        if (rd !== model[addr[3:2]]) begin
            errors++;
            $display("FAIL split_readback got %h want %h", rd, model[addr[3:2]]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, old_v;
        do_write(4'hC, 32'h11, 4'hF);
        old_v = model[3];
        bus.S_AXI_AWADDR = 4'hC; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h22; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_ARADDR = 4'hC; bus.S_AXI_ARVALID = 1'b1;
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
            errors++;
            $display("FAIL same_cycle_ready got %b want 111",
                     {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
        end
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        model[3] = 32'h22;
        checks++;
        if ({bus.S_AXI_RVALID, bus.S_AXI_BVALID} !== 2'b11 || bus.S_AXI_RDATA !== old_v) begin
            errors++;
            $display("FAIL same_cycle_read got rv/bv=%b rdata=%h want 11 %h",
                     {bus.S_AXI_RVALID, bus.S_AXI_BVALID}, bus.S_AXI_RDATA, old_v);
        end
        bus.S_AXI_RREADY = 1'b1; bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b0;
        do_read(4'hC, rd);
        checks++;
        if (rd !== 32'h22) begin
            errors++;
            $display("FAIL same_cycle_after got %h want 00000022", rd);
        end
    endtask

    task automatic test_led_static();
        do_write(4'h0, 32'h0, 4'hF);
        for (int n = 0; n < 4; n++) begin
            do_write(4'h4, $urandom, 4'hF);
            checks++;
            if (led_o !== model[1][LW-1:0]) begin
                errors++;
                $display("FAIL led_static got %h want %h", led_o, model[1][LW-1:0]);
            end
        end
    endtask

`ifdef ENDEAVOUR_LED_BLINK_EN
    task automatic test_blink();
        logic [31:0] pat, per;
        logic [LW-1:0] exp_led;
        for (int n = 0; n < 2; n++) begin
            pat = (n == 0) ? 32'hA5 : $urandom;
            per = (n == 0) ? 32'd4 : 32'($urandom_range(1, 5));
            do_write(4'h4, pat, 4'hF);
            do_write(4'h8, per, 4'hF);
            // Enable blinking with a single-cycle AW+W so the commit edge is known.
            bus.S_AXI_AWADDR = 4'h0; bus.S_AXI_AWVALID = 1'b1;
            bus.S_AXI_WDATA = 32'h1; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
            tick();
            bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b1;
            model[0] = 32'h1;
            for (int k = 1; k <= 4 * int'(per); k++) begin
                tick();
                bus.S_AXI_BREADY = 1'b0;
                exp_led = ((((k - 1) / int'(per)) % 2) == 0) ? pat[LW-1:0] : '0;
                checks++;
                if (led_o !== exp_led) begin
                    errors++;
                    $display("FAIL blink per=%0d k=%0d got %h want %h", per, k, led_o, exp_led);
                end
            end
            do_write(4'h8, 32'h0, 4'hF);
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (led_o !== pat[LW-1:0]) begin
                    errors++;
                    $display("FAIL blink_period0 k=%0d got %h want %h", k, led_o, pat[LW-1:0]);
                end
                tick();
            end
        end
        do_write(4'h0, 32'h0, 4'hF);
    endtask
`else
    task automatic test_blink();
        do_write(4'h4, 32'hA5, 4'hF);
        do_write(4'h8, 32'h2, 4'hF);
        do_write(4'h0, 32'h1, 4'hF);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (led_o !== model[1][LW-1:0]) begin
                errors++;
                $display("FAIL no_blink k=%0d got %h want %h", k, led_o, model[1][LW-1:0]);
            end
            tick();
        end
        do_write(4'h0, 32'h0, 4'hF);
    endtask
`endif

    task automatic test_reset_mid();
        do_write(4'h4, 32'hFF, 4'hF);
        do_write(4'hC, 32'hDEAD_BEEF, 4'hF);
        bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        checks++;
        if (bus.S_AXI_WREADY !== 1'b1 || led_o === '0) begin
            errors++;
            $display("FAIL mid_setup got wready=%b led=%h want 1 nonzero", bus.S_AXI_WREADY, led_o);
        end
        #2 ARESETN = 1'b0;
        #1 check_idle_outputs("mid_async_reset");
        tick();
        ARESETN = 1'b1;
        for (int i = 0; i < 4; i++) model[i] = '0;
        tick();
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_BVALID} !== 2'b10 || led_o !== '0) begin
            errors++;
            $display("FAIL mid_release got awready/bvalid=%b led=%h want 10 0",
                     {bus.S_AXI_AWREADY, bus.S_AXI_BVALID}, led_o);
        end
        read_all("mid_regs");
        checks++;
        if (bus.S_AXI_BVALID !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_bresp got %b want 0", bus.S_AXI_BVALID);
        end
    endtask

    initial begin
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0;
        bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
        test_reset();
        test_regmap();
        test_random();
        test_strobe();
        test_split(1'b1);
        test_split(1'b0);
        test_back_to_back();
        test_led_static();
        test_blink();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
